// File: rtl/fft_16pt_32bit_pkg.sv
// fft16_pkg: shared types, constants, twiddle ROM and helpers for the 16-point FFT
package fft16_pkg;
  localparam int DW = 32;
  localparam int N = 16;
  localparam int LOG2N = 4;
  localparam int TW_FRAC = 14;
  localparam logic signed [32:0] RND = 33'sd1 <<< (TW_FRAC - 1);
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;
  typedef enum logic {IDLE, RUN} state_t;
  localparam cplx_t TW [8] = '{
    '{16'sd16384, 16'sd0},
    '{16'sd15137, -16'sd6270},
    '{16'sd11585, -16'sd11585},
    '{16'sd6270, -16'sd15137},
    '{16'sd0, -16'sd16384},
    '{-16'sd6270, -16'sd15137},
    '{-16'sd11585, -16'sd11585},
    '{-16'sd15137, -16'sd6270}
  };
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction
  function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
    return v > 19'sd32767 ? 16'sh7fff : v < -19'sd32768 ? 16'sh8000 : v[15:0];
  endfunction
endpackage

// File: rtl/fft_16pt_32bit_if.sv
// fft_16pt_32bit_if: frame start/data/done bundle between frame buffer and FFT
interface fft_16pt_32bit_if;
  import fft16_pkg::*;
  logic start;
  logic [DW-1:0] in [15:0];
  logic [DW-1:0] out [15:0];
  logic done;
  modport master (output start, in, input out, done);
  modport slave (input start, in, output out, done);
endinterface

// File: rtl/fft_16pt_32bit_butterfly.sv
// fft16_butterfly: radix-2 DIT butterfly with rounding and saturation; FFT16_STAGE_SCALE_EN halves each output
module fft16_butterfly
  import fft16_pkg::*;
(
  input  cplx_t a,
  input  cplx_t b,
  input  cplx_t w,
  output cplx_t a_out,
  output cplx_t b_out
);
  logic signed [32:0] pr, pi;
  logic signed [18:0] tr, ti;
`ifdef FFT16_STAGE_SCALE_EN
  function automatic logic signed [18:0] fin(input logic signed [18:0] v);
    return (v + 19'sd1) >>> 1;
  endfunction
`else
  function automatic logic signed [18:0] fin(input logic signed [18:0] v);
    return v;
  endfunction
`endif
  assign pr = 33'(b.re) * 33'(w.re) - 33'(b.im) * 33'(w.im);
  assign pi = 33'(b.re) * 33'(w.im) + 33'(b.im) * 33'(w.re);
  assign tr = 19'((pr + RND) >>> TW_FRAC);
  assign ti = 19'((pi + RND) >>> TW_FRAC);
  assign a_out = {sat16(fin(19'(a.re) + tr)), sat16(fin(19'(a.im) + ti))};
  assign b_out = {sat16(fin(19'(a.re) - tr)), sat16(fin(19'(a.im) - ti))};
endmodule

// File: rtl/fft_16pt_32bit.sv
// fft_16pt_32bit: 4-stage pipelined 16-point radix-2 DIT FFT; FFT16_STAGE_SCALE_EN selects DFT/16 output
module fft_16pt_32bit
  import fft16_pkg::*;
(
  input logic clk,
  input logic reset,
  fft_16pt_32bit_if.slave bus
);
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  cplx_t stg_q [LOG2N][N];
  cplx_t res [LOG2N][N];
  cplx_t out_q [N];
  for (genvar s = 0; s < LOG2N; s++) begin : g_stg
    for (genvar i = 0; i < N / 2; i++) begin : g_bf
      localparam int H = 1 << s;
      localparam int T = (i / H) * 2 * H + i % H;
      fft16_butterfly u_bf (
        .a(stg_q[s][T]),
        .b(stg_q[s][T+H]),
        .w(TW[(i % H) * (8 / H)]),
        .a_out(res[s][T]),
        .b_out(res[s][T+H])
      );
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_out
    assign bus.out[k] = out_q[k];
  end
  assign bus.done = done_q;
  // accept a frame when idle, then count the four stage edges and pulse done on the last
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = bus.start ? RUN : IDLE;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 2'd1;
      done_d = cnt_q == 2'd3;
      state_d = cnt_q == 2'd3 ? IDLE : RUN;
    end
  end
  // control state, bit-reversed capture, stage pipeline and held output spectrum
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      done_q <= 1'b0;
      stg_q <= '{default: '0};
      out_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
      if (state_q == IDLE && bus.start)
        for (int n = 0; n < N; n++) stg_q[0][n] <= cplx_t'(bus.in[bitrev4(4'(n))]);
      for (int s = 1; s < LOG2N; s++) stg_q[s] <= res[s-1];
      if (done_d) out_q <= res[LOG2N-1];
    end
  end
endmodule

// File: tb/tb_fft_16pt_32bit.sv
// tb_fft_16pt_32bit: directed-vector self-checking bench for the 16-point FFT
module tb_fft_16pt_32bit;
`ifdef FFT16_STAGE_SCALE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_run = 0;
  int n_fail = 0;
  fft_16pt_32bit_if bus();
  fft_16pt_32bit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp, input int tol = 0);
    n_run++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int re_of(input logic [31:0] w);
    return int'($signed(w[31:16]));
  endfunction

  function automatic int im_of(input logic [31:0] w);
    return int'($signed(w[15:0]));
  endfunction

  function automatic int sc(input int v);
    return SH != 0 ? (v + (v < 0 ? -8 : 8)) / 16 : v;
  endfunction

  task automatic set_all(input int re);
    for (int n = 0; n < 16; n++) bus.in[n] = {16'(re), 16'h0};
  endtask

  task automatic set_ramp();
    for (int n = 0; n < 16; n++) bus.in[n] = {16'(100 * n), 16'h0};
  endtask

  task automatic set_imp(input int amp);
    set_all(0);
    bus.in[0] = {16'(amp), 16'h0};
  endtask

  task automatic frame(input string tag);
    int first = -1;
    int cnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        cnt++;
        if (first < 0) first = c;
      end
    end
    chk({tag, "_lat"}, first, 4);
    chk({tag, "_pulses"}, cnt, 1);
  endtask

  initial begin
    int tl;
    tl = SH != 0 ? 3 : 2;
    bus.start = 1'b0;
    set_all(0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", int'(bus.done), 0);
    chk("rst_out0", re_of(bus.out[0]), 0);
    chk("rst_out15", im_of(bus.out[15]), 0);
    @(negedge clk);
    reset = 1'b0;

    set_ramp();
    frame("ramp");
    chk("ramp_x0_re", re_of(bus.out[0]), sc(12000), tl);
    chk("ramp_x0_im", im_of(bus.out[0]), 0, tl);
    chk("ramp_x8_re", re_of(bus.out[8]), sc(-800), tl);
    chk("ramp_x8_im", im_of(bus.out[8]), 0, tl);
    chk("ramp_x4_re", re_of(bus.out[4]), sc(-800), tl);
    chk("ramp_x4_im", im_of(bus.out[4]), sc(800), tl);
    chk("ramp_x1_re", re_of(bus.out[1]), sc(-800), tl);
    chk("ramp_x1_im", im_of(bus.out[1]), sc(4022), tl);
    chk("ramp_x15_re", re_of(bus.out[15]), sc(-800), tl);
    chk("ramp_x15_im", im_of(bus.out[15]), sc(-4022), tl);

    set_imp(1000);
    frame("imp");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("imp_x%0d_re", k), re_of(bus.out[k]), sc(1000), SH);
      chk($sformatf("imp_x%0d_im", k), im_of(bus.out[k]), 0);
    end

    set_all(500);
    frame("const");
    chk("const_x0_re", re_of(bus.out[0]), sc(8000), 1);
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("const_x%0d_re", k), re_of(bus.out[k]), 0, 1);
      chk($sformatf("const_x%0d_im", k), im_of(bus.out[k]), 0, 1);
    end

    set_all(30000);
    frame("ovf");
`ifdef FFT16_STAGE_SCALE_EN
    chk("ovf_x0_re", re_of(bus.out[0]), 30000);
`else
    chk("ovf_x0_re", re_of(bus.out[0]), 32767);
`endif
    chk("ovf_x3_re", re_of(bus.out[3]), 0);

    set_ramp();
    for (int cyc = 0; cyc <= 10; cyc++) begin
      @(negedge clk);
      bus.start = cyc == 0 || cyc == 2;
      @(posedge clk);
      #1;
      chk($sformatf("busy_done_c%0d", cyc), int'(bus.done), int'(cyc == 4));
    end

    for (int cyc = 0; cyc <= 21; cyc++) begin
      @(negedge clk);
      bus.start = cyc % 6 == 0 && cyc < 18;
      if (cyc % 6 == 0 && cyc < 18) set_imp(1000 * (cyc / 6 + 1));
      @(posedge clk);
      #1;
      chk($sformatf("b2b_done_c%0d", cyc), int'(bus.done),
          int'(cyc >= 4 && cyc <= 16 && (cyc - 4) % 6 == 0));
      if (cyc >= 4)
        chk($sformatf("b2b_hold_c%0d", cyc), re_of(bus.out[5]),
            sc(1000 * ((cyc - 4) / 6 > 2 ? 3 : (cyc - 4) / 6 + 1)), SH);
    end

    set_ramp();
    for (int cyc = 0; cyc <= 9; cyc++) begin
      @(negedge clk);
      bus.start = cyc == 0;
      reset = cyc == 2;
      @(posedge clk);
      #1;
      chk($sformatf("abort_done_c%0d", cyc), int'(bus.done), 0);
    end
    chk("abort_out0", re_of(bus.out[0]), 0);
    chk("abort_out5", re_of(bus.out[5]), 0);
    chk("abort_out1", im_of(bus.out[1]), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
